// File: rtl/topk_stream_sorter.sv
// Streaming top-K selector.
// Keeps the best DEPTH entries seen since the last init, ranked by the low
// KEY_WIDTH bits of each entry. It keeps either the largest or the smallest
// keys, depending on MAX_MODE. A flush drains the kept entries in rank order
// over a valid/ready stream.
//
// state  | meaning
// ACCEPT | taking entries on din, single-cycle sorted insert
// DRAIN  | presenting slot[0] on dout, shifting the list up on each handshake
module topk_stream_sorter #(
  parameter int DATA_WIDTH = 16,
  parameter int KEY_WIDTH  = 12,
  parameter int DEPTH      = 64,
  parameter bit MAX_MODE   = 1'b1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  init,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic [CW-1:0]         count
);

  typedef enum logic {ACCEPT = 1'b0, DRAIN = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] slot_q [DEPTH];
  logic [DATA_WIDTH-1:0] slot_d [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  dout_last_q, dout_last_d;

  logic [KEY_WIDTH-1:0]  key;
  logic [DEPTH-1:0]      better;
  logic                  pop;

  // Rank the incoming key against every slot; an empty slot always loses.
  // Equal keys are not "better", so a newer duplicate lands behind the older one.
  always_comb begin
    key = din[KEY_WIDTH-1:0];
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i]) begin
        better[i] = 1'b1;
      end else if (MAX_MODE) begin
        better[i] = key > slot_q[i][KEY_WIDTH-1:0];
      end else begin
        better[i] = key < slot_q[i][KEY_WIDTH-1:0];
      end
    end
  end

  // A drain beat leaves only when the registered valid is seen with ready.
  assign pop = (state_q == DRAIN) && dout_valid_q && dout_ready;

  // Next-state for storage, count and mode; init overrides everything.
  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    count_d = count_q;
    state_d = state_q;

    if (init) begin
      valid_d = '0;
      count_d = '0;
      state_d = ACCEPT;
    end else if (state_q == ACCEPT) begin
      if (din_valid) begin
        // The first "better" slot takes din, everything behind it moves down
        // one place; the old last entry falls off the end when full.
        if (better[0]) begin
          slot_d[0]  = din;
          valid_d[0] = 1'b1;
        end
        for (int i = 1; i < DEPTH; i++) begin
          if (better[i] && better[i-1]) begin
            slot_d[i]  = slot_q[i-1];
            valid_d[i] = valid_q[i-1];
          end else if (better[i]) begin
            slot_d[i]  = din;
            valid_d[i] = 1'b1;
          end
        end
        if (count_q != CW'(DEPTH)) begin
          count_d = count_q + CW'(1);
        end
      end
      // A same-cycle accept counts as content, so the flush is honoured.
      if (flush && ((count_q != '0) || din_valid)) begin
        state_d = DRAIN;
      end
    end else if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        slot_d[i]  = slot_q[i+1];
        valid_d[i] = valid_q[i+1];
      end
      valid_d[DEPTH-1] = 1'b0;
      count_d = count_q - CW'(1);
      if (count_q == CW'(1)) begin
        state_d = ACCEPT;
      end
    end
  end

  // Output registers are loaded from next-state so dout tracks slot[0] with
  // no combinational path from din or dout_ready; dout holds when idle.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    dout_last_d  = 1'b0;
    if (state_d == DRAIN) begin
      dout_d       = slot_d[0];
      dout_valid_d = valid_d[0];
      dout_last_d  = (count_d == CW'(1));
    end
  end

  // State, storage and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ACCEPT;
      valid_q      <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign din_ready  = (state_q == ACCEPT);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign count      = count_q;

endmodule

// File: tb/tb_topk_stream_sorter.sv
// Bench for topk_stream_sorter: one largest-key and one smallest-key instance
// share the same stimulus; each has its own expected-output queue and monitor.
module tb_topk_stream_sorter;

  localparam int DW = 16;
  localparam int KW = 12;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          init = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          flush = 1'b0;
  logic          dout_ready = 1'b0;

  logic          din_ready_mx, dout_valid_mx, dout_last_mx;
  logic [DW-1:0] dout_mx;
  logic [CW-1:0] count_mx;
  logic          din_ready_mn, dout_valid_mn, dout_last_mn;
  logic [DW-1:0] dout_mn;
  logic [CW-1:0] count_mn;

  int errors = 0;
  int checks = 0;

  logic [DW:0] q_mx[$];
  logic [DW:0] q_mn[$];

  always #5 clk = ~clk;

  topk_stream_sorter #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .DEPTH(D), .MAX_MODE(1'b1)) u_mx (
    .clk(clk), .rstn(rstn), .init(init), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_mx), .flush(flush), .dout(dout_mx), .dout_valid(dout_valid_mx),
    .dout_ready(dout_ready), .dout_last(dout_last_mx), .count(count_mx));

  topk_stream_sorter #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .DEPTH(D), .MAX_MODE(1'b0)) u_mn (
    .clk(clk), .rstn(rstn), .init(init), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_mn), .flush(flush), .dout(dout_mn), .dout_valid(dout_valid_mn),
    .dout_ready(dout_ready), .dout_last(dout_last_mn), .count(count_mn));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    din = d;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic load_six();
    send(16'h0005); send(16'h1009); send(16'h2001);
    send(16'h3007); send(16'h4003); send(16'h5009);
  endtask

  task automatic push_mx(input logic [DW-1:0] d, input logic last);
    q_mx.push_back({last, d});
  endtask

  task automatic push_mn(input logic [DW-1:0] d, input logic last);
    q_mn.push_back({last, d});
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Wait for both scoreboards to empty, bounded; ends on the final handshake edge.
  task automatic wait_drain(input string name);
    int n = 0;
    while ((q_mx.size() > 0 || q_mn.size() > 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (q_mx.size() > 0 || q_mn.size() > 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d/%0d beats left expected 0", name, q_mx.size(), q_mn.size());
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_rdy_mx"}, din_ready_mx, 1);
    chk({name, "_val_mx"}, dout_valid_mx, 0);
    chk({name, "_cnt_mx"}, count_mx, 0);
    chk({name, "_rdy_mn"}, din_ready_mn, 1);
    chk({name, "_val_mn"}, dout_valid_mn, 0);
    chk({name, "_cnt_mn"}, count_mn, 0);
  endtask

  // Monitors: every handshake must match the head of its expected queue.
  always @(negedge clk) begin
    if (rstn && dout_valid_mx && dout_ready) begin
      if (q_mx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mx_unexpected: got %0h expected no beat", {dout_last_mx, dout_mx});
      end else begin
        chk("mx_beat", {dout_last_mx, dout_mx}, q_mx.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && dout_valid_mn && dout_ready) begin
      if (q_mn.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mn_unexpected: got %0h expected no beat", {dout_last_mn, dout_mn});
      end else begin
        chk("mn_beat", {dout_last_mn, dout_mn}, q_mn.pop_front());
      end
    end
  end

  initial begin
    // Reset held, then released.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("rst_hold");
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk_idle("rst_rel");

    // Both modes, no backpressure.
    tick();
    load_six();
    chk("load_cnt_mx", count_mx, 4);
    chk("load_cnt_mn", count_mn, 4);
    push_mx(16'h1009, 0); push_mx(16'h5009, 0); push_mx(16'h3007, 0); push_mx(16'h0005, 1);
    push_mn(16'h2001, 0); push_mn(16'h4003, 0); push_mn(16'h0005, 0); push_mn(16'h3007, 1);
    dout_ready = 1'b1;
    do_flush();
    chk("drain_rdy_mx", din_ready_mx, 0);
    wait_drain("s2");
    @(negedge clk);
    chk_idle("s2_end");

    // Backpressure after the first beat.
    tick();
    load_six();
    push_mx(16'h1009, 0); push_mx(16'h5009, 0); push_mx(16'h3007, 0); push_mx(16'h0005, 1);
    push_mn(16'h2001, 0); push_mn(16'h4003, 0); push_mn(16'h0005, 0); push_mn(16'h3007, 1);
    do_flush();
    tick();
    dout_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_dout_mx", dout_mx, 16'h5009);
      chk("bp_val_mx", dout_valid_mx, 1);
      chk("bp_cnt_mx", count_mx, 3);
      chk("bp_dout_mn", dout_mn, 16'h4003);
      chk("bp_cnt_mn", count_mn, 3);
    end
    @(posedge clk);
    #1 dout_ready = 1'b1;
    wait_drain("s4");
    @(negedge clk);
    chk_idle("s4_end");

    // init after two drained beats, then an empty flush.
    tick();
    load_six();
    push_mx(16'h1009, 0); push_mx(16'h5009, 0);
    push_mn(16'h2001, 0); push_mn(16'h4003, 0);
    do_flush();
    tick();
    tick();
    dout_ready = 1'b0;
    init = 1'b1;
    tick();
    init = 1'b0;
    @(negedge clk);
    chk_idle("s5_init");
    chk("s5_q_mx", q_mx.size(), 0);
    chk("s5_q_mn", q_mn.size(), 0);
    @(posedge clk);
    #1 dout_ready = 1'b1;
    do_flush();
    repeat (3) begin
      @(negedge clk);
      chk_idle("s5_eflush");
    end

    // Flush together with a new entry.
    tick();
    send(16'h1004);
    send(16'h2002);
    push_mx(16'h300A, 0); push_mx(16'h1004, 0); push_mx(16'h2002, 1);
    push_mn(16'h2002, 0); push_mn(16'h1004, 0); push_mn(16'h300A, 1);
    din = 16'h300A;
    din_valid = 1'b1;
    do_flush();
    din_valid = 1'b0;
    wait_drain("s6");
    @(negedge clk);
    chk_idle("s6_end");

    // flush and init together: init wins.
    tick();
    send(16'h0007);
    chk("fi_pre_cnt", count_mx, 1);
    flush = 1'b1;
    init = 1'b1;
    tick();
    flush = 1'b0;
    init = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_idle("fi");
    end

    // Async reset in the middle of a drain.
    tick();
    dout_ready = 1'b0;
    send(16'h0011);
    send(16'h0022);
    do_flush();
    @(negedge clk);
    chk("ar_val_mx", dout_valid_mx, 1);
    chk("ar_cnt_mx", count_mx, 2);
    #2 rstn = 1'b0;
    #1;
    chk_idle("ar");
    @(posedge clk);
    #1 rstn = 1'b1;

    chk("end_q_mx", q_mx.size(), 0);
    chk("end_q_mn", q_mn.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
